// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, instruction format encoding and decode entry type
//
// Shared by the decode core and the decode stage.
//   OPC_*       : base opcode constants for the formats the decoder recognises
//   instr_fmt_e : one-hot instruction format {J,U,B,S,I,R}, R in bit 0, zero = illegal
//   decode_t    : one decoded instruction as stored in the decode-stage FIFO
//
// pc and imm are held at XLEN_MAX bits so the same entry type serves any
// stage XLEN up to 64; the stage zero-extends pc, sign-extends imm and
// trims both back to its own XLEN on the way out.

package riscv_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [5:0] {
    FMT_NONE = 6'b000000,
    FMT_R    = 6'b000001,
    FMT_I    = 6'b000010,
    FMT_S    = 6'b000100,
    FMT_B    = 6'b001000,
    FMT_U    = 6'b010000,
    FMT_J    = 6'b100000
  } instr_fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    instr_fmt_e          fmt;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } decode_t;

endpackage

// File: rtl/riscv_decode_core.sv
// rtl/riscv_decode_core.sv - combinational RV32I instruction field, format and immediate decode
//
// Ports:
//   instr_i                 in  32  instruction word
//   rs1_o, rs2_o, rd_o      out 5   raw register index fields
//   op_o                    out 7   opcode field
//   funct3_o, funct7_o      out 3/7 raw funct fields
//   fmt_o                   out 6   one-hot format {J,U,B,S,I,R}, 0 when illegal
//   imm_o                   out 32  immediate, already sign-extended to 32 bits
//   illegal_o               out 1   opcode unknown or instr[1:0] != 2'b11

module riscv_decode_core
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [5:0]  fmt_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  instr_fmt_e  fmt;
  logic [31:0] imm;

  // Raw fields go through untouched regardless of format or legality.
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign rd_o     = instr_i[11:7];
  assign op_o     = instr_i[6:0];
  assign funct3_o = instr_i[14:12];
  assign funct7_o = instr_i[31:25];

  always_comb begin
    fmt = FMT_NONE;
    case (instr_i[6:0])
      OPC_OP:                          fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  fmt = FMT_I;
      OPC_STORE:                       fmt = FMT_S;
      OPC_BRANCH:                      fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
      OPC_JAL:                         fmt = FMT_J;
      default:                         fmt = FMT_NONE;
    endcase
    // Compressed-space encodings are not supported by this core.
    if (instr_i[1:0] != 2'b11) begin
      fmt = FMT_NONE;
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
      FMT_U: imm = {instr_i[31:12], 12'b0};
      FMT_J: imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign fmt_o     = fmt;
  assign imm_o     = imm;
  assign illegal_o = (fmt == FMT_NONE);

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered RV32I decode stage with DEPTH-entry output FIFO
//
// Parameters: XLEN (data/PC width), DEPTH (FIFO entries, >= 1), CNT_W (illegal counter width)
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   in_valid_i / in_ready_o       fetch handshake; pc_i, instr_i offered instruction
//   flush_i                       drop every buffered entry and the current offer
//   out_valid_o / out_ready_i     execute handshake on the FIFO head
//   pc_o, rs1_o, rs2_o, rd_o, op_o, funct3_o, funct7_o, fmt_o, imm_o, illegal_o
//                                 head entry fields, all zero while empty
//   illegal_cnt_o                 saturating count of accepted illegal instructions

module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [6:0]       op_o,
  output logic [2:0]       funct3_o,
  output logic [6:0]       funct7_o,
  output logic [5:0]       fmt_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]  core_rs1, core_rs2, core_rd;
  logic [6:0]  core_op, core_funct7;
  logic [2:0]  core_funct3;
  logic [5:0]  core_fmt;
  logic [31:0] core_imm;
  logic        core_illegal;

  riscv_decode_core u_core (
    .instr_i   (instr_i),
    .rs1_o     (core_rs1),
    .rs2_o     (core_rs2),
    .rd_o      (core_rd),
    .op_o      (core_op),
    .funct3_o  (core_funct3),
    .funct7_o  (core_funct7),
    .fmt_o     (core_fmt),
    .imm_o     (core_imm),
    .illegal_o (core_illegal)
  );

  decode_t entry_d;

  always_comb begin
    entry_d         = '0;
    entry_d.pc      = XLEN_MAX'(pc_i);
    entry_d.rs1     = core_rs1;
    entry_d.rs2     = core_rs2;
    entry_d.rd      = core_rd;
    entry_d.op      = core_op;
    entry_d.funct3  = core_funct3;
    entry_d.funct7  = core_funct7;
    entry_d.fmt     = instr_fmt_e'(core_fmt);
    entry_d.imm     = XLEN_MAX'($signed(core_imm));
    entry_d.illegal = core_illegal;
  end

  decode_t          mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on stored occupancy only, so a pop in a full cycle
  // cannot open a same-cycle push.
  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Counts instructions actually accepted; flush leaves the history intact.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (push && entry_d.illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  decode_t head;
  logic    unused_head;

  assign head        = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign unused_head = ^{head.pc, head.imm};

  assign pc_o          = head.pc[XLEN-1:0];
  assign rs1_o         = head.rs1;
  assign rs2_o         = head.rs2;
  assign rd_o          = head.rd;
  assign op_o          = head.op;
  assign funct3_o      = head.funct3;
  assign funct7_o      = head.funct7;
  assign fmt_o         = head.fmt;
  assign imm_o         = head.imm[XLEN-1:0];
  assign illegal_o     = head.illegal;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - directed and randomised checks of riscv_decode_stage

module tb_riscv_decode_stage;

  logic clk, reset_n;
  int   checks, passed;

  // Instance A: DEPTH 2, CNT_W 16
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_pc_i, a_instr, a_pc_o, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3;
  logic [5:0]  a_fmt;
  logic        a_ill;
  logic [15:0] a_cnt;

  // Instance B: DEPTH 3, CNT_W 2
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_pc_i, b_instr, b_pc_o, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3;
  logic [5:0]  b_fmt;
  logic        b_ill;
  logic [1:0]  b_cnt;

  riscv_decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .pc_i(a_pc_i), .instr_i(a_instr), .flush_i(a_flush), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .pc_o(a_pc_o), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
    .op_o(a_op), .funct3_o(a_f3), .funct7_o(a_f7), .fmt_o(a_fmt), .imm_o(a_imm),
    .illegal_o(a_ill), .illegal_cnt_o(a_cnt)
  );

  riscv_decode_stage #(.XLEN(32), .DEPTH(3), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .pc_i(b_pc_i), .instr_i(b_instr), .flush_i(b_flush), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .pc_o(b_pc_o), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
    .op_o(b_op), .funct3_o(b_f3), .funct7_o(b_f7), .fmt_o(b_fmt), .imm_o(b_imm),
    .illegal_o(b_ill), .illegal_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_in_valid = 1'b1; a_pc_i = 32'h40; a_instr = 32'hFFF10093;
    step(); step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else passed++;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else passed++;
    checks++; if (a_pc_o !== 32'h0 || a_imm !== 32'h0 || a_fmt !== 6'h0) $display("FAIL reset_data_zero: got pc %h imm %h fmt %h expected 0", a_pc_o, a_imm, a_fmt); else passed++;
    checks++; if (a_cnt !== 16'h0) $display("FAIL reset_cnt: got %0d expected 0", a_cnt); else passed++;
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) $display("FAIL reset_b_flags: got valid %b ready %b expected 0/1", b_out_valid, b_in_ready); else passed++;
    // mid-operation reset drops a buffered entry
    reset_n = 1'b1; a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) $display("FAIL midreset_prefill: got %b expected 1", a_out_valid); else passed++;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++; if (a_out_valid !== 1'b0 || a_pc_o !== 32'h0) $display("FAIL midreset_discard: got valid %b pc %h expected 0/0", a_out_valid, a_pc_o); else passed++;
  endtask

  task automatic test_i_type();
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_pc_i = 32'h100; a_instr = 32'hFFF10093;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) $display("FAIL itype_valid: got %b expected 1", a_out_valid); else passed++;
    checks++; if (a_fmt !== 6'b000010) $display("FAIL itype_fmt: got %b expected 000010", a_fmt); else passed++;
    checks++; if (a_rd !== 5'd1 || a_rs1 !== 5'd2) $display("FAIL itype_regs: got rd %0d rs1 %0d expected 1/2", a_rd, a_rs1); else passed++;
    checks++; if (a_imm !== 32'hFFFFFFFF) $display("FAIL itype_imm: got %h expected ffffffff", a_imm); else passed++;
    checks++; if (a_pc_o !== 32'h100) $display("FAIL itype_pc: got %h expected 100", a_pc_o); else passed++;
    checks++; if (a_op !== 7'b0010011 || a_f3 !== 3'd0 || a_ill !== 1'b0) $display("FAIL itype_op: got op %b f3 %0d ill %b expected 0010011/0/0", a_op, a_f3, a_ill); else passed++;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_imm !== 32'h0 || a_rd !== 5'd0) $display("FAIL itype_drain: got valid %b imm %h rd %0d expected 0", a_out_valid, a_imm, a_rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5] = '{32'h00512423, 32'hFE000EE3, 32'h123452B7, 32'h002081B3, 32'h0080006F};
    logic [5:0]  fmt [5] = '{6'b000100, 6'b001000, 6'b010000, 6'b000001, 6'b100000};
    logic [31:0] imm [5] = '{32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h0, 32'h8};
    logic [4:0]  rd  [5] = '{5'd8, 5'd29, 5'd5, 5'd3, 5'd0};
    logic [4:0]  rs2 [5] = '{5'd5, 5'd0, 5'd3, 5'd2, 5'd8};
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_pc_i = 32'h200 + 32'(4 * i); a_instr = ins[i];
      step();
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1) $display("FAIL b2b_flags[%0d]: got valid %b ready %b expected 1/1", i, a_out_valid, a_in_ready); else passed++;
      checks++; if (a_fmt !== fmt[i]) $display("FAIL b2b_fmt[%0d]: got %b expected %b", i, a_fmt, fmt[i]); else passed++;
      checks++; if (a_imm !== imm[i]) $display("FAIL b2b_imm[%0d]: got %h expected %h", i, a_imm, imm[i]); else passed++;
      checks++; if (a_pc_o !== 32'h200 + 32'(4 * i)) $display("FAIL b2b_pc[%0d]: got %h expected %h", i, a_pc_o, 32'h200 + 32'(4 * i)); else passed++;
      checks++; if (a_rd !== rd[i] || a_rs2 !== rs2[i]) $display("FAIL b2b_regs[%0d]: got rd %0d rs2 %0d expected %0d/%0d", i, a_rd, a_rs2, rd[i], rs2[i]); else passed++;
    end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", a_out_valid); else passed++;
  endtask

  task automatic test_illegal();
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_pc_i = 32'h300; a_instr = 32'h00000000;
    step();
    checks++; if (a_ill !== 1'b1 || a_fmt !== 6'h0 || a_imm !== 32'h0) $display("FAIL ill_zero: got ill %b fmt %h imm %h expected 1/0/0", a_ill, a_fmt, a_imm); else passed++;
    checks++; if (a_cnt !== 16'd1) $display("FAIL ill_cnt1: got %0d expected 1", a_cnt); else passed++;
    a_instr = 32'hFFF10090;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_ill !== 1'b1 || a_fmt !== 6'h0 || a_rd !== 5'd1) $display("FAIL ill_lsb: got ill %b fmt %h rd %0d expected 1/0/1", a_ill, a_fmt, a_rd); else passed++;
    checks++; if (a_cnt !== 16'd2) $display("FAIL ill_cnt2: got %0d expected 2", a_cnt); else passed++;
    step();
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_instr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      b_pc_i = 32'h500 + 32'(4 * i);
      step();
      checks++; if (b_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) $display("FAIL ill_sat[%0d]: got %0d expected %0d", i, b_cnt, (i < 3) ? i + 1 : 3); else passed++;
    end
    b_in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = 32'h002081B3;
    a_pc_i = 32'h400;
    step();
    checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || a_pc_o !== 32'h400) $display("FAIL bp_one: got valid %b ready %b pc %h expected 1/1/400", a_out_valid, a_in_ready, a_pc_o); else passed++;
    a_pc_i = 32'h404;
    step();
    checks++; if (a_in_ready !== 1'b0 || a_pc_o !== 32'h400) $display("FAIL bp_full: got ready %b pc %h expected 0/400", a_in_ready, a_pc_o); else passed++;
    a_pc_i = 32'h408;
    step();
    checks++; if (a_in_ready !== 1'b0 || a_pc_o !== 32'h400 || a_rd !== 5'd3) $display("FAIL bp_hold: got ready %b pc %h rd %0d expected 0/400/3", a_in_ready, a_pc_o, a_rd); else passed++;
    a_out_ready = 1'b1;
    step();
    checks++; if (a_in_ready !== 1'b1 || a_pc_o !== 32'h404) $display("FAIL bp_pop1: got ready %b pc %h expected 1/404", a_in_ready, a_pc_o); else passed++;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_pc_o !== 32'h408) $display("FAIL bp_pop2: got valid %b pc %h expected 1/408", a_out_valid, a_pc_o); else passed++;
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", a_out_valid); else passed++;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = 32'h002081B3;
    a_pc_i = 32'h600; step();
    a_pc_i = 32'h604; step();
    checks++; if (a_in_ready !== 1'b0) $display("FAIL flush_prefill: got ready %b expected 0", a_in_ready); else passed++;
    a_flush = 1'b1; a_pc_i = 32'h608;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL flush_full: got valid %b ready %b expected 0/1", a_out_valid, a_in_ready); else passed++;
    a_in_valid = 1'b1; a_pc_i = 32'h610;
    step();
    a_flush = 1'b1; a_pc_i = 32'h614; a_instr = 32'h0;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_drop: got valid %b expected 0", a_out_valid); else passed++;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_pc_o !== 32'h0) $display("FAIL flush_stays_empty: got valid %b pc %h expected 0/0", a_out_valid, a_pc_o); else passed++;
    checks++; if (a_cnt !== 16'd2) $display("FAIL flush_cnt_kept: got %0d expected 2", a_cnt); else passed++;
  endtask

  task automatic test_stress();
    logic [31:0] q [$];
    logic [31:0] next_pc;
    int          mcount;
    logic        psh, pp;
    next_pc = 32'h1000;
    mcount  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (b_out_valid !== (mcount != 0)) $display("FAIL stress_valid@%0d: got %b expected %b", cyc, b_out_valid, mcount != 0); else passed++;
      checks++; if (b_in_ready !== (mcount < 3)) $display("FAIL stress_ready@%0d: got %b expected %b", cyc, b_in_ready, mcount < 3); else passed++;
      if (mcount != 0) begin
        checks++; if (b_pc_o !== q[0]) $display("FAIL stress_pc@%0d: got %h expected %h", cyc, b_pc_o, q[0]); else passed++;
        checks++; if (b_imm !== (q[0] & 32'h7FF)) $display("FAIL stress_imm@%0d: got %h expected %h", cyc, b_imm, q[0] & 32'h7FF); else passed++;
      end
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_pc_i      = next_pc;
      b_instr     = {1'b0, next_pc[10:0], 5'd3, 3'b000, 5'd1, 7'b0010011};
      psh = b_in_valid && (mcount < 3);
      pp  = b_out_ready && (mcount != 0);
      step();
      if (pp) void'(q.pop_front());
      if (psh) begin
        q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      mcount = mcount + int'(psh) - int'(pp);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (b_out_valid !== 1'b0) $display("FAIL stress_drain: got %b expected 0", b_out_valid); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0; a_pc_i = '0; a_instr = '0;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0; b_pc_i = '0; b_instr = '0;
    test_reset();
    test_i_type();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    test_stress();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
